// File: rtl/shift_pipe_unit_pkg.sv
// Shared constants and op encodings for the shift/rotate pipeline.
package shift_pipe_unit_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  // Every shift op is executed as a left rotation followed by a zero mask.
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shift_op_e;

endpackage

// File: rtl/rotl16.sv
// 16-bit combinational left rotator.
module rotl16 (
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  output logic [15:0] Out
);

  logic [31:0] doubled;

  // Shift a doubled copy left; the upper half is the rotated word.
  always_comb begin
    doubled = {In, In} << Cnt;
    Out     = doubled[31:16];
  end

endmodule

// File: rtl/shift_mask_gen.sv
// Zero mask that turns a left rotation into a logical shift.
module shift_mask_gen
  import shift_pipe_unit_pkg::*;
(
  input  shift_op_e          op,
  input  logic [CNT_W-1:0]   cnt,
  output logic [WIDTH-1:0]   mask
);

  localparam logic [WIDTH-1:0] ONES = '1;

  // Rotates keep every bit; SLL clears the low cnt bits, SRL the high cnt bits.
  // cnt = 0 naturally yields all ones for the shift ops.
  always_comb begin
    mask = ONES;
    case (op)
      OP_SLL:  mask = ONES << cnt;
      OP_SRL:  mask = ONES >> cnt;
      default: mask = ONES;
    endcase
  end

endmodule

// File: rtl/shift_pipe_unit.sv
// Two-stage 16-bit shift/rotate unit: S1 holds the request, S2 holds the result.
module shift_pipe_unit
  import shift_pipe_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_zero,
  output logic              busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on stage state, out_ready and flush (never on
  // in_valid); out_valid/out_data/out_zero are held until out_ready is seen.

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic [CNT_W-1:0]  s1_cnt;
  shift_op_e         s1_op;

  logic              s2_valid;
  logic [WIDTH-1:0]  s2_data;
  logic              s2_zero;

  logic              adv2;
  logic              accept;
  logic              load2;
  logic [CNT_W-1:0]  rot;
  logic [WIDTH-1:0]  rv;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  result;

  assign adv2     = !s2_valid || out_ready;
  assign in_ready = (!s1_valid || adv2) && !flush;
  assign accept   = in_valid && in_ready;
  assign load2    = s1_valid && adv2;

  // Right-going ops become a left rotation by (16 - cnt) mod 16.
  always_comb begin
    rot = s1_cnt;
    if (s1_op == OP_ROR || s1_op == OP_SRL) begin
      rot = ~s1_cnt + 1'b1;
    end
  end

  rotl16 u_rot (
    .In  (s1_data),
    .Cnt (rot),
    .Out (rv)
  );

  shift_mask_gen u_mask (
    .op   (s1_op),
    .cnt  (s1_cnt),
    .mask (mask)
  );

  assign result = rv & mask;

  // Pipeline registers: flush kills both stages and wins over any advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_op    <= OP_ROL;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zero  <= 1'b1;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
      end
      if (load2) begin
        s2_data <= result;
        s2_zero <= (result == '0);
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_cnt   <= in_cnt;
        s1_op    <= shift_op_e'(in_op);
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_zero;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Bench for shift_pipe_unit: queue-based reference model plus directed cases.
module tb_shift_pipe_unit;

  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRL = 2'b11;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: in-flight results (oldest first) and edges since accept.
  logic [15:0] exp_q[$];
  int          age_q[$];

  // Results observed leaving the unit, with the cycle they left.
  logic [15:0] pop_log[$];
  int          pop_cyc[$];

  shift_pipe_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Shift semantics straight from the op definitions, in plain integer math.
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                            input logic [3:0] c);
    int x;
    int n;
    int r;
    x = int'(d);
    n = int'(c);
    case (op)
      ROL:     r = (x << n) | (x >> (16 - n));
      SLL:     r = x << n;
      ROR:     r = (x >> n) | (x << (16 - n));
      default: r = x >> n;
    endcase
    return r[15:0];
  endfunction

  // Compare process: check outputs mid-cycle, advance the model at the edge.
  always begin
    logic pred_valid;
    logic pred_ready;
    logic acc;
    logic pop;
    @(negedge clk);
    if (!rst) begin
      pred_valid = (exp_q.size() > 0) && (age_q[0] >= 1);
      pred_ready = !flush && (exp_q.size() < 2 || out_ready);
      check("out_valid", out_valid, pred_valid);
      check("in_ready", in_ready, pred_ready);
      check("busy", busy, exp_q.size() > 0);
      if (pred_valid) begin
        check("out_data", out_data, exp_q[0]);
        check("out_zero", out_zero, exp_q[0] == 16'h0);
      end
      if (out_valid && out_ready && !flush) begin
        pop_log.push_back(out_data);
        pop_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    if (rst || flush) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      pred_valid = (exp_q.size() > 0) && (age_q[0] >= 1);
      pred_ready = exp_q.size() < 2 || out_ready;
      acc = in_valid && pred_ready;
      pop = pred_valid && out_ready;
      if (pop) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (acc) begin
        exp_q.push_back(ref_shift(in_op, in_data, in_cnt));
        age_q.push_back(0);
      end
    end
  end

  task automatic set_req(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c);
    in_op   = op;
    in_data = d;
    in_cnt  = c;
  endtask

  // One request into an idle unit with out_ready high; pins the 2-cycle latency.
  task automatic run_one(input string name, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] c, input logic [15:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_req(op, d, c);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, exp);
    check({name, "_zero"}, out_zero, exp == 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_idle", busy, 1'b0);
  endtask

  // Stimulus.
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_req(ROL, 16'h0, 4'h0);

    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, 16'h0);
    check("rst_out_zero", out_zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    #2;
    rst = 1'b0;

    // First accept in the first cycle after reset release.
    run_one("rol_basic", ROL, 16'h8001, 4'd1, 16'h0003);
    run_one("ror_basic", ROR, 16'h0001, 4'd4, 16'h1000);
    run_one("sll_15", SLL, 16'hFFFF, 4'd15, 16'h8000);
    run_one("srl_15", SRL, 16'hFFFF, 4'd15, 16'h0001);
    run_one("srl_0", SRL, 16'h8000, 4'd0, 16'h8000);
    run_one("sll_0", SLL, 16'h0001, 4'd0, 16'h0001);
    run_one("srl_zero", SRL, 16'h0001, 4'd1, 16'h0000);

    // Backpressure: two accepted, third held until the consumer is ready.
    drain();
    pop_log.delete();
    pop_cyc.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(ROL, 16'h1234, 4'd4);
    @(posedge clk); #1;
    set_req(ROL, 16'h1234, 4'd8);
    @(posedge clk); #1;
    set_req(ROL, 16'h1234, 4'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_in_ready", in_ready, 1'b0);
      check("bp_held_valid", out_valid, 1'b1);
      check("bp_held_data", out_data, 16'h2341);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("bp_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check("bp_res0", pop_log[0], 16'h2341);
      check("bp_res1", pop_log[1], 16'h3412);
      check("bp_res2", pop_log[2], 16'h4123);
    end

    // Full-rate streaming.
    pop_log.delete();
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      set_req(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", pop_log.size(), 8);
    if (pop_log.size() == 8) begin
      for (int i = 1; i < 8; i++) begin
        check("stream_back_to_back", pop_cyc[i], pop_cyc[0] + i);
      end
    end

    // Flush with both stages valid and a request on the input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(SLL, 16'h0F0F, 4'd2);
    @(posedge clk); #1;
    set_req(SRL, 16'hF0F0, 4'd3);
    @(posedge clk); #1;
    set_req(ROL, 16'hABCD, 4'd5);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_not_accepted", busy, 1'b0);
    @(posedge clk); #1;
    run_one("after_flush", SLL, 16'h00F0, 4'd4, 16'h0F00);

    // Asynchronous reset with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(ROL, 16'h00FF, 4'd4);
    @(posedge clk); #1;
    set_req(ROR, 16'hFF00, 4'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_out_data", out_data, 16'h0);
    check("arst_out_zero", out_zero, 1'b1);
    check("arst_in_ready", in_ready, 1'b1);
    @(negedge clk); #2;
    rst = 1'b0;
    run_one("after_arst", SRL, 16'h8421, 4'd4, 16'h0842);

    // Randomised traffic with backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      set_req(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_pipe_unit.md
Name: shift_pipe_unit

Overview:
- Two-stage pipelined 16-bit shift/rotate execution unit for the datapath's shift instructions (ROL, SLL, ROR, SRL).
- Accepts one request per cycle over a valid/ready handshake and normalises every operation to a left rotation plus a zero mask.
- Returns the result with valid/ready backpressure.
- Sits between the decode/operand-fetch stage and the writeback mux.

Parameters:
- WIDTH, 16, data width; only 16 is supported.
- CNT_W, 4, shift-count width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  request present
- in_ready  output  1  unit can accept request this cycle
- in_data  input  16  operand
- in_cnt  input  4  shift/rotate amount, 0..15
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  16  result
- out_zero  output  1  out_data == 0
- busy  output  1  either pipeline stage valid

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high. All other inputs are sampled on the rising edge of clk.
- Reset values:
  - s1_valid = 0, s2_valid = 0, in_ready = 1, out_valid = 0, out_data = 0, out_zero = 1, busy = 0.
  - All stage payload registers clear to 0.
- Stage 1 (S1) registers {data, cnt, op} on accept.
- Accept rule: accept = in_valid && in_ready.
- Rotate amount, computed combinationally from S1:
  - ROL, SLL: rot = cnt.
  - ROR, SRL: rot = (16 - cnt) mod 16, in 4-bit arithmetic, so cnt = 0 gives rot = 0.
- Rotated value: rv = data rotated left by rot.
- Mask:
  - ROL, ROR: all ones.
  - SLL: low cnt bits cleared.
  - SRL: high cnt bits cleared.
  - cnt = 0: all ones for every op.
- Stage 2 (S2) registers result = rv & mask and zero = (result == 0).
- Advance rules:
  - adv2 = !s2_valid || out_ready.
  - S1 moves into S2 when s1_valid && adv2.
  - in_ready = (!s1_valid || adv2) && !flush. This is purely combinational from state, out_ready and flush; no dependence on in_valid.
- Latency and throughput:
  - An accept at edge N gives out_valid = 1 after edge N+1, i.e. 2 cycles, when unstalled.
  - Sustained throughput is 1 result per cycle.
- Output stability: while out_valid && !out_ready, out_data and out_zero hold stable and no result is dropped or duplicated.
- Full condition: both stages valid and out_ready low gives in_ready = 0. Ordering is strictly FIFO; the maximum number of in-flight requests is 2.
- Simultaneous events: an output pop and an input accept in the same cycle are both honoured; S1 moves to S2 in the same edge.
- Flush:
  - flush = 1 at an edge clears s1_valid and s2_valid; any request presented that cycle is not accepted.
  - Flush takes priority over all advances.
  - Payload registers need not clear.
- Reset mid-operation: asserting rst drops all in-flight results immediately, asynchronously. The first accept is possible in the first cycle after rst deasserts.
- busy = s1_valid || s2_valid.
- No arithmetic shift. in_op values outside the encoding cannot occur (2-bit field, fully decoded).

Decomposition:
- Shared package holds:
  - Op encodings: OP_ROL = 2'b00, OP_SLL = 2'b01, OP_ROR = 2'b10, OP_SRL = 2'b11.
  - WIDTH and CNT_W constants.
- Rotation reuses the team's existing 16-bit left-rotate unit (In/Cnt/Out), driven with rv/rot.
- One new combinational sub-module is natural: shift_mask_gen (inputs op, cnt; output 16-bit mask).
- Handshake and pipeline registers stay in shift_pipe_unit.

Test Plan:
- ROL 0x8001 cnt 1, out_ready held 1: out_valid rises 2 cycles after accept with out_data 0x0003, out_zero 0. Then ROR 0x0001 cnt 4 gives 0x1000.
- Shift boundaries:
  - SLL 0xFFFF cnt 15 gives 0x8000.
  - SRL 0xFFFF cnt 15 gives 0x0001.
  - SRL 0x8000 cnt 0 gives 0x8000.
  - SLL 0x0001 cnt 0 gives 0x0001.
  - SRL 0x0001 cnt 1 gives 0x0000 with out_zero 1.
- Backpressure: out_ready = 0, present three back-to-back requests (ROL 0x1234 by 4, 8, 12).
  - First two accepted; in_ready drops; third held.
  - Raise out_ready: results 0x2341, 0x3412, 0x4123 appear in order, each exactly once.
- Full-rate streaming: 8 consecutive requests with out_ready = 1 give 8 results on 8 consecutive cycles, and in_ready stays 1 throughout.
- Flush: with both stages valid, pulse flush for one cycle while in_valid = 1.
  - Next cycle out_valid = 0 and busy = 0; the flush-cycle request is not accepted.
  - A request offered after the flush returns the correct result 2 cycles later.
- Async reset: assert rst between clock edges with 2 results in flight. out_valid, busy and out_data drop to 0 immediately, without a clock edge; in_ready = 1.
